keyed_seq_detector: RTL and testbench

- Parametrised, key-locked sequence-detector FSM for the locking benchmark set.
- Generalises single-bit duplicated-state locking to a KEY_W-bit key, loaded serially through a handshake, with one key bit gating each forward transition.
- With the correct key it detects a PAT_LEN-symbol pattern and counts matches; with a wrong key, traffic diverts through decoy duplicate states and matches are silently lost.
- Sits between the stimulus stream and the benchmark output bus.

---
 rtl/keyed_seq_pkg.sv | 49 ++++
 rtl/keyed_seq_detector_key_shift_loader.sv | 56 +++++
 rtl/keyed_seq_detector.sv | 114 +++++++++++
 tb/tb_keyed_seq_detector.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_seq_pkg.sv
// ---------------------------------------------------------------------------
// keyed_seq_pkg
// Shared definitions for the key-locked sequence detector:
//   - state kind enum (idle / true progress / decoy duplicate)
//   - state_dbg encoding constants and width
//   - helper that extracts pattern symbol k from the packed pattern
// ---------------------------------------------------------------------------
package keyed_seq_pkg;

    localparam int STATE_DBG_W  = 6;
    localparam int IDLE_CODE    = 0;
    localparam int S_BASE       = 0;
    localparam int D_BASE       = 16;

    // Upper bounds for the generic pattern-symbol helper.
    localparam int MAX_SYM_W    = 32;
    localparam int MAX_PAT_BITS = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRUE  = 2'd1,
        ST_DECOY = 2'd2
    } state_kind_e;

    // Symbol k of a packed pattern; symbol 0 sits in the least-significant bits.
    function automatic logic [MAX_SYM_W-1:0] pattern_sym(
        input logic [MAX_PAT_BITS-1:0] pattern,
        input int unsigned             sym_w,
        input int unsigned             k
    );
        logic [MAX_SYM_W-1:0] mask;
        mask = (sym_w >= MAX_SYM_W) ? '1
                                    : ((MAX_SYM_W'(1) << sym_w) - MAX_SYM_W'(1));
        return MAX_SYM_W'(pattern >> (k * sym_w)) & mask;
    endfunction

    // Observable state code: IDLE=0, S_k=S_BASE+k, D_k=D_BASE+k.
    function automatic logic [STATE_DBG_W-1:0] encode_state(
        input state_kind_e kind,
        input int unsigned pos
    );
        case (kind)
            ST_TRUE:  return STATE_DBG_W'(S_BASE + pos);
            ST_DECOY: return STATE_DBG_W'(D_BASE + pos);
            default:  return STATE_DBG_W'(IDLE_CODE);
        endcase
    endfunction

endpackage

// File: rtl/keyed_seq_detector_key_shift_loader.sv
// ---------------------------------------------------------------------------
// key_shift_loader
// Serial key register. Bits arrive LSB first through a valid/ready handshake;
// once KEY_W bits are taken the loader stops accepting and reports the key as
// loaded. Only reset can clear it for a reload.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   key_bit_i    in   serial key data
//   key_valid_i  in   key_bit_i valid this cycle
//   key_ready_o  out  loader accepts key bits
//   key_loaded_o out  full key held
//   key_o        out  assembled key
// ---------------------------------------------------------------------------
module key_shift_loader #(
    parameter int KEY_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_bit_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    output logic             key_loaded_o,
    output logic [KEY_W-1:0] key_o
);

    localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] idx_q;
    logic             loaded_q;
    logic             accept;

    assign accept = key_valid_i & ~loaded_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q    <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
        end else if (accept) begin
            key_q[idx_q] <= key_bit_i;
            if (idx_q == IDX_W'(KEY_W - 1)) begin
                loaded_q <= 1'b1;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign key_ready_o  = ~loaded_q;
    assign key_loaded_o = loaded_q;
    assign key_o        = key_q;

endmodule

// File: rtl/keyed_seq_detector.sv
// ---------------------------------------------------------------------------
// keyed_seq_detector
// Key-locked sequence detector. With the correct key loaded it detects a
// PAT_LEN-symbol pattern, pulses match and counts matches. A wrong key bit at
// any step diverts traffic into decoy states that look identical from the
// outputs but never complete a match.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   key_bit    in   serial key data (LSB first)
//   key_valid  in   key_bit valid this cycle
//   key_ready  out  block accepts key bits
//   key_loaded out  full key held, detector armed
//   sym_in     in   input symbol
//   sym_valid  in   sym_in valid this cycle
//   match      out  one-cycle pulse after the completing symbol
//   match_cnt  out  saturating match count
//   state_dbg  out  encoded present state (verification only)
// ---------------------------------------------------------------------------
module keyed_seq_detector
    import keyed_seq_pkg::*;
#(
    parameter int                         SYM_W     = 4,
    parameter int                         PAT_LEN   = 4,
    parameter logic [PAT_LEN*SYM_W-1:0]   PATTERN   = 16'h3A5C,
    parameter int                         KEY_W     = PAT_LEN,
    parameter logic [KEY_W-1:0]           KEY_CONST = 4'b1011,
    parameter int                         CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_bit,
    input  logic                   key_valid,
    output logic                   key_ready,
    output logic                   key_loaded,
    input  logic [SYM_W-1:0]       sym_in,
    input  logic                   sym_valid,
    output logic                   match,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [STATE_DBG_W-1:0] state_dbg
);

    localparam int POS_W = $clog2(PAT_LEN);

    logic [KEY_W-1:0] key;
    state_kind_e      kind_q;
    logic [POS_W-1:0] pos_q;   // symbol index expected next (0 in IDLE)
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;

    logic [SYM_W-1:0] exp_sym;
    logic [SYM_W-1:0] first_sym;
    logic             key_ok;
    logic             restart_ok;
    logic             last_pos;

    key_shift_loader #(.KEY_W(KEY_W)) u_loader (
        .clk          (clk),
        .rst          (rst),
        .key_bit_i    (key_bit),
        .key_valid_i  (key_valid),
        .key_ready_o  (key_ready),
        .key_loaded_o (key_loaded),
        .key_o        (key)
    );

    assign exp_sym    = SYM_W'(pattern_sym(MAX_PAT_BITS'(PATTERN), SYM_W, 32'(pos_q)));
    assign first_sym  = SYM_W'(pattern_sym(MAX_PAT_BITS'(PATTERN), SYM_W, 0));
    assign key_ok     = (key[pos_q] == KEY_CONST[pos_q]);
    assign restart_ok = (key[0] == KEY_CONST[0]);
    assign last_pos   = (pos_q == POS_W'(PAT_LEN - 1));

    // key_loaded gates the FSM; the load-completing cycle still sees it low,
    // so a symbol presented then is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q  <= ST_IDLE;
            pos_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= 1'b0;
            if (key_loaded && sym_valid) begin
                if (sym_in == exp_sym) begin
                    if (last_pos) begin
                        kind_q <= ST_IDLE;
                        pos_q  <= '0;
                        // Decoy paths and a wrong final key bit finish silently.
                        if (kind_q != ST_DECOY && key_ok) begin
                            match_q <= 1'b1;
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        pos_q  <= pos_q + POS_W'(1);
                        kind_q <= (kind_q != ST_DECOY && key_ok) ? ST_TRUE : ST_DECOY;
                    end
                end else if (kind_q != ST_IDLE && sym_in == first_sym) begin
                    // Mismatch that is itself a valid first symbol: restart at position 1.
                    pos_q  <= POS_W'(1);
                    kind_q <= restart_ok ? ST_TRUE : ST_DECOY;
                end else begin
                    kind_q <= ST_IDLE;
                    pos_q  <= '0;
                end
            end
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign state_dbg = encode_state(kind_q, 32'(pos_q));

endmodule

// File: tb/tb_keyed_seq_detector.sv
module tb_keyed_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] sym_in = 4'h0;
    logic       sym_valid = 1'b0;

    logic       key_ready, key_loaded, match;
    logic [7:0] match_cnt;
    logic [5:0] state_dbg;

    logic       s_key_ready, s_key_loaded, s_match;
    logic [1:0] s_match_cnt;
    logic [5:0] s_state_dbg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    keyed_seq_detector dut (
        .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
        .key_ready(key_ready), .key_loaded(key_loaded), .sym_in(sym_in),
        .sym_valid(sym_valid), .match(match), .match_cnt(match_cnt),
        .state_dbg(state_dbg)
    );

    // Same stimulus, 2-bit counter, for saturation.
    keyed_seq_detector #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
        .key_ready(s_key_ready), .key_loaded(s_key_loaded), .sym_in(sym_in),
        .sym_valid(sym_valid), .match(s_match), .match_cnt(s_match_cnt),
        .state_dbg(s_state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        key_valid = 1'b0;
        sym_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic load_key(input logic [3:0] k);
        for (int i = 0; i < 4; i++) begin
            key_bit = k[i];
            key_valid = 1'b1;
            step();
            key_valid = 1'b0;
        end
    endtask

    task automatic send_sym(input logic [3:0] s);
        sym_in = s;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_vec++;
        if (key_ready !== 1'b1 || key_loaded !== 1'b0 || match !== 1'b0 ||
            match_cnt !== 8'd0 || state_dbg !== 6'd0) begin
            n_err++;
            $display("FAIL reset: ready=%b loaded=%b match=%b cnt=%0d state=%0d, want 1 0 0 0 0",
                     key_ready, key_loaded, match, match_cnt, state_dbg);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_key_load();
        logic [3:0] k;
        k = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();                      // gap cycle with key_valid low
            key_bit = k[i];
            key_valid = 1'b1;
            step();
            key_valid = 1'b0;
            n_vec++;
            if (i < 3) begin
                if (key_ready !== 1'b1 || key_loaded !== 1'b0) begin
                    n_err++;
                    $display("FAIL key_load_bit%0d: ready=%b loaded=%b, want 1 0", i, key_ready, key_loaded);
                end
            end else begin
                if (key_ready !== 1'b0 || key_loaded !== 1'b1) begin
                    n_err++;
                    $display("FAIL key_load_done: ready=%b loaded=%b, want 0 1", key_ready, key_loaded);
                end
            end
        end
        n_vec++;
        if (dut.u_loader.key_q !== 4'b1011) begin
            n_err++;
            $display("FAIL key_reg: got %b, want 1011", dut.u_loader.key_q);
        end
        // Extra key bits after loading are ignored.
        key_bit = 1'b0;
        key_valid = 1'b1;
        step();
        step();
        key_valid = 1'b0;
        n_vec++;
        if (dut.u_loader.key_q !== 4'b1011 || key_loaded !== 1'b1) begin
            n_err++;
            $display("FAIL key_ignore: key=%b loaded=%b, want 1011 1", dut.u_loader.key_q, key_loaded);
        end
    endtask

    task automatic test_correct_key();
        logic [3:0] syms [4]  = '{4'hC, 4'h5, 4'hA, 4'h3};
        int         path [4]  = '{1, 2, 3, 0};
        do_reset();
        load_key(4'b1011);
        for (int i = 0; i < 4; i++) begin
            send_sym(syms[i]);
            n_vec++;
            if (state_dbg !== 6'(path[i]) || match !== (i == 3)) begin
                n_err++;
                $display("FAIL correct_step%0d: state=%0d match=%b, want %0d %b",
                         i, state_dbg, match, path[i], (i == 3));
            end
        end
        n_vec++;
        if (match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL correct_cnt: got %0d, want 1", match_cnt);
        end
        step();
        n_vec++;
        if (match !== 1'b0 || match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL correct_pulse_end: match=%b cnt=%0d, want 0 1", match, match_cnt);
        end
    endtask

    task automatic test_wrong_key();
        logic [3:0] syms [4] = '{4'hC, 4'h5, 4'hA, 4'h3};
        int         path [4] = '{1, 18, 19, 0};
        do_reset();
        load_key(4'b1001);
        for (int i = 0; i < 4; i++) begin
            send_sym(syms[i]);
            n_vec++;
            if (state_dbg !== 6'(path[i]) || match !== 1'b0) begin
                n_err++;
                $display("FAIL wrong_step%0d: state=%0d match=%b, want %0d 0",
                         i, state_dbg, match, path[i]);
            end
        end
        step();
        n_vec++;
        if (match !== 1'b0 || match_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wrong_cnt: match=%b cnt=%0d, want 0 0", match, match_cnt);
        end
    endtask

    task automatic test_restart();
        logic [3:0] syms [6] = '{4'hC, 4'h5, 4'hC, 4'h5, 4'hA, 4'h3};
        int         path [6] = '{1, 2, 1, 2, 3, 0};
        do_reset();
        load_key(4'b1011);
        for (int i = 0; i < 6; i++) begin
            send_sym(syms[i]);
            n_vec++;
            if (state_dbg !== 6'(path[i]) || match !== (i == 5)) begin
                n_err++;
                $display("FAIL restart_step%0d: state=%0d match=%b, want %0d %b",
                         i, state_dbg, match, path[i], (i == 5));
            end
        end
        n_vec++;
        if (match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL restart_cnt: got %0d, want 1", match_cnt);
        end
        // Unrelated symbol from S_1 returns to IDLE.
        send_sym(4'hC);
        send_sym(4'h7);
        n_vec++;
        if (state_dbg !== 6'd0) begin
            n_err++;
            $display("FAIL restart_abort: state=%0d, want 0", state_dbg);
        end
    endtask

    task automatic test_gating();
        do_reset();
        send_sym(4'hC);
        send_sym(4'h5);
        n_vec++;
        if (state_dbg !== 6'd0 || match !== 1'b0) begin
            n_err++;
            $display("FAIL gate_unloaded: state=%0d match=%b, want 0 0", state_dbg, match);
        end
        // Three key bits, then the last bit together with a valid first symbol.
        for (int i = 0; i < 3; i++) begin
            key_bit = (i != 2);
            key_valid = 1'b1;
            step();
        end
        key_bit = 1'b1;
        sym_in = 4'hC;
        sym_valid = 1'b1;
        step();
        key_valid = 1'b0;
        sym_valid = 1'b0;
        n_vec++;
        if (key_loaded !== 1'b1 || state_dbg !== 6'd0) begin
            n_err++;
            $display("FAIL gate_load_cycle: loaded=%b state=%0d, want 1 0", key_loaded, state_dbg);
        end
        send_sym(4'hC);
        n_vec++;
        if (state_dbg !== 6'd1) begin
            n_err++;
            $display("FAIL gate_armed: state=%0d, want 1", state_dbg);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] syms [4] = '{4'hC, 4'h5, 4'hA, 4'h3};
        do_reset();
        load_key(4'b1011);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) send_sym(syms[i]);
            n_vec++;
            if (s_match !== 1'b1 || s_match_cnt !== 2'((p + 1 > 3) ? 3 : p + 1) ||
                match_cnt !== 8'(p + 1)) begin
                n_err++;
                $display("FAIL sat_pat%0d: match=%b cnt2=%0d cnt8=%0d, want 1 %0d %0d",
                         p, s_match, s_match_cnt, match_cnt, (p + 1 > 3) ? 3 : p + 1, p + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_key(4'b1011);
        send_sym(4'hC);
        send_sym(4'h5);
        send_sym(4'hA);
        send_sym(4'h3);
        send_sym(4'hC);
        send_sym(4'h5);
        n_vec++;
        if (state_dbg !== 6'd2 || match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL areset_pre: state=%0d cnt=%0d, want 2 1", state_dbg, match_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (state_dbg !== 6'd0 || match !== 1'b0 || match_cnt !== 8'd0 ||
            key_ready !== 1'b1 || key_loaded !== 1'b0 || dut.u_loader.key_q !== 4'b0000) begin
            n_err++;
            $display("FAIL areset: state=%0d match=%b cnt=%0d ready=%b loaded=%b key=%b, want 0 0 0 1 0 0000",
                     state_dbg, match, match_cnt, key_ready, key_loaded, dut.u_loader.key_q);
        end
        step();
        rst = 1'b1;
        send_sym(4'hA);
        send_sym(4'h3);
        n_vec++;
        if (match !== 1'b0 || state_dbg !== 6'd0) begin
            n_err++;
            $display("FAIL areset_after: match=%b state=%0d, want 0 0", match, state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_correct_key();
        test_wrong_key();
        test_restart();
        test_gating();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
